// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch PC block: FSM encoding and default address map.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } fetch_state_t;

    localparam logic [31:0] FETCH_RESET_ADDR = 32'h0000_3000;
    localparam logic [31:0] FETCH_EXC_ADDR   = 32'h0000_4180;
    localparam logic [31:0] FETCH_TEXT_LO    = 32'h0000_3000;
    localparam logic [31:0] FETCH_TEXT_HI    = 32'h0000_6FFC;

endpackage

// File: rtl/redirect_buf.sv
// Holds a branch target that arrived while the pipeline was stalled.
module redirect_buf #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              clear,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);

    // load wins over clear: a fresh stalled branch always replaces the old one
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)   q <= '0;
        else if (load)  q <= d;
        else if (clear) q <= '0;
    end

endmodule

// File: rtl/fetch_pc.sv
// Fetch program counter with stall-tolerant branch buffering and exception redirects.
module fetch_pc
    import fetch_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(FETCH_RESET_ADDR),
    parameter logic [ADDR_W-1:0] EXC_ADDR   = ADDR_W'(FETCH_EXC_ADDR),
    parameter logic [ADDR_W-1:0] TEXT_LO    = ADDR_W'(FETCH_TEXT_LO),
    parameter logic [ADDR_W-1:0] TEXT_HI    = ADDR_W'(FETCH_TEXT_HI)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_req,
    input  logic              eret_req,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              fetch_valid,
    output logic              adel,
    output logic              pend
);

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pend_tgt;
    logic              buf_load, buf_clr;

    redirect_buf #(.ADDR_W(ADDR_W)) u_buf (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (buf_load),
        .clear  (buf_clr),
        .d      (br_target),
        .q      (pend_tgt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= BOOT;
            pc    <= RESET_ADDR;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        buf_load  = 1'b0;
        buf_clr   = 1'b0;
        case (state)
            BOOT: state_nxt = RUN;
            RUN, PEND: begin
                if (exc_req) begin
                    pc_nxt    = EXC_ADDR;
                    buf_clr   = 1'b1;
                    state_nxt = RUN;
                end else if (eret_req) begin
                    pc_nxt    = epc;
                    buf_clr   = 1'b1;
                    state_nxt = RUN;
                end else if (br_valid && en) begin
                    pc_nxt    = br_target;
                    buf_clr   = 1'b1;
                    state_nxt = RUN;
                end else if (br_valid) begin
                    // stalled branch: remember it, keep fetching the same pc
                    buf_load  = 1'b1;
                    state_nxt = PEND;
                end else if (en && state == PEND) begin
                    pc_nxt    = pend_tgt;
                    buf_clr   = 1'b1;
                    state_nxt = RUN;
                end else if (en) begin
                    pc_nxt    = pc_plus4;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end

    assign pc_plus4    = pc + ADDR_W'(4);
    assign fetch_valid = (state == RUN) || (state == PEND);
    assign pend        = (state == PEND);
    assign adel        = (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);

endmodule
